// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single MMU port between instruction fetch (IF)
// and the MEM-stage load/store requester.
//
// Each transaction latches the granted request, drives the MMU from those
// latched fields until mmu_mem_ready, and then answers with a registered
// one-cycle ready pulse. MEM has priority over IF. MEM_STREAK_MAX bounds how
// many MEM grants in a row can pass over a pending fetch. A taken branch
// (if_flush) discards a fetch that is already in flight.
//
// Optional build macro: ARB_TIMEOUT_EN. When it is defined, a BUSY access that
// runs for TIMEOUT_CYCLES cycles is aborted. It answers with rdata 0, and a
// MEM access also raises mem_error.
//
// state    | meaning
// IDLE     | no transaction, arbitrating every cycle
// BUSY_IF  | fetch access driven to the MMU, waiting for mmu_mem_ready
// BUSY_MEM | load/store access driven to the MMU, waiting for mmu_mem_ready
// RESP     | one-cycle response to the owner, re-arbitrates the other requester

`ifndef MMU_WIDTH_WORD
`define MMU_WIDTH_WORD 2'b10
`endif

module mem_port_arbiter #(
    parameter int unsigned MEM_STREAK_MAX = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic        mem_signed,
    input  logic [1:0]  mem_width,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        if_stall,
    output logic        mem_stall,
    output logic        mmu_read_enable,
    output logic        mmu_write_enable,
    output logic        mmu_mem_signed_read,
    output logic [1:0]  mmu_mem_data_width,
    output logic [31:0] mmu_address,
    output logic [31:0] mmu_data_in,
    input  logic        mmu_mem_ready,
    input  logic [31:0] mmu_data_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MEM_STREAK_MAX);

    state_t      state_q, state_d;
    logic        owner_if_q;
    logic        drop_q;
    logic [3:0]  streak_q;
    logic [31:0] lat_addr_q;
    logic [31:0] lat_wdata_q;
    logic        lat_we_q;
    logic        lat_signed_q;
    logic [1:0]  lat_width_q;
    logic [31:0] if_rdata_q;
    logic [31:0] mem_rdata_q;

    logic busy;
    logic arb_en;
    logic resp_if;
    logic resp_mem;
    logic if_pending;
    logic can_if;
    logic can_mem;
    logic force_if;
    logic grant_if;
    logic grant_mem;
    logic timeout_hit;
    logic busy_done;

    // The requester being answered in RESP still holds its (old) request, so
    // it is masked out of that cycle's arbitration. A fetch counts as pending
    // for the streak even while it is being flushed.
    assign busy       = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
    assign arb_en     = (state_q == IDLE) || (state_q == RESP);
    assign resp_if    = (state_q == RESP) && owner_if_q;
    assign resp_mem   = (state_q == RESP) && !owner_if_q;
    assign if_pending = if_req && !resp_if;
    assign can_if     = if_pending && !if_flush;
    assign can_mem    = mem_req && !resp_mem;
    assign force_if   = can_if && (streak_q == STREAK_MAX);
    assign grant_mem  = arb_en && can_mem && !force_if;
    assign grant_if   = arb_en && can_if && !grant_mem;
    assign busy_done  = mmu_mem_ready || timeout_hit;

    // Next-state: grant out of IDLE or RESP, and leave BUSY when the access completes or aborts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: begin
                if (grant_mem)
                    state_d = BUSY_MEM;
                else if (grant_if)
                    state_d = BUSY_IF;
                else
                    state_d = IDLE;
            end
            BUSY_IF, BUSY_MEM: begin
                if (busy_done)
                    state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, request latch, streak counter, fetch drop flag and response data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_if_q   <= 1'b0;
            drop_q       <= 1'b0;
            streak_q     <= 4'd0;
            lat_addr_q   <= 32'd0;
            lat_wdata_q  <= 32'd0;
            lat_we_q     <= 1'b0;
            lat_signed_q <= 1'b0;
            lat_width_q  <= 2'd0;
            if_rdata_q   <= 32'd0;
            mem_rdata_q  <= 32'd0;
        end else begin
            state_q <= state_d;

            if (grant_if || grant_mem) begin
                owner_if_q   <= grant_if;
                lat_addr_q   <= grant_if ? if_addr : mem_addr;
                lat_we_q     <= grant_mem && mem_we;
                lat_signed_q <= grant_mem && mem_signed;
                lat_width_q  <= grant_if ? `MMU_WIDTH_WORD : mem_width;
                lat_wdata_q  <= grant_if ? 32'd0 : mem_wdata;
            end

            if (grant_if)
                streak_q <= 4'd0;
            else if (grant_mem) begin
                if (!if_pending)
                    streak_q <= 4'd0;
                else if (streak_q != STREAK_MAX)
                    streak_q <= streak_q + 4'd1;
            end

            if ((state_q == BUSY_IF) && if_flush)
                drop_q <= 1'b1;
            else if (state_q == RESP)
                drop_q <= 1'b0;

            if (busy && busy_done) begin
                if (state_q == BUSY_IF)
                    if_rdata_q <= timeout_hit ? 32'd0 : mmu_data_out;
                else
                    mem_rdata_q <= (lat_we_q || timeout_hit) ? 32'd0 : mmu_data_out;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_q;
    logic        err_q;

    assign timeout_hit = busy && !mmu_mem_ready && (tmo_q == 16'd0);
    assign mem_error   = mem_ready && err_q;

    // Down-counter reloaded on every grant. At terminal count 0, the BUSY
    // state has lasted TIMEOUT_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            if (grant_if || grant_mem)
                tmo_q <= TMO_LOAD;
            else if (busy && (tmo_q != 16'd0))
                tmo_q <= tmo_q - 16'd1;

            if (busy && busy_done)
                err_q <= timeout_hit && (state_q == BUSY_MEM);
        end
    end
`else
    // No abort path: BUSY waits for the MMU indefinitely. The expression
    // references TIMEOUT_CYCLES but always evaluates to 0.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
    assign mem_error   = 1'b0;
`endif

    assign if_ready  = resp_if && !drop_q;
    assign mem_ready = resp_mem;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_stall  = if_req && !if_ready;
    assign mem_stall = mem_req && !mem_ready;

    // The MMU is driven only from latched fields and only during BUSY. These
    // are decoded from state, so an asynchronous reset drops the strobes at once.
    assign mmu_read_enable     = busy && !lat_we_q;
    assign mmu_write_enable    = busy && lat_we_q;
    assign mmu_mem_signed_read = busy && lat_signed_q;
    assign mmu_mem_data_width  = busy ? lat_width_q : 2'd0;
    assign mmu_address         = busy ? lat_addr_q : 32'd0;
    assign mmu_data_in         = (busy && lat_we_q) ? lat_wdata_q : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table of single transactions plus hand-built
// collision, starvation, flush, reset and (when ARB_TIMEOUT_EN is defined) timeout sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, if_flush, mem_req, mem_we, mem_signed, mmu_mem_ready;
    logic [1:0]  mem_width;
    logic [31:0] if_addr, mem_addr, mem_wdata, mmu_data_out;
    logic        if_ready, mem_ready, mem_error, if_stall, mem_stall;
    logic        mmu_read_enable, mmu_write_enable, mmu_mem_signed_read;
    logic [1:0]  mmu_mem_data_width;
    logic [31:0] if_rdata, mem_rdata, mmu_address, mmu_data_in;

    int n_chk = 0;
    int n_fail = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_signed(mem_signed),
        .mem_width(mem_width), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .if_stall(if_stall), .mem_stall(mem_stall),
        .mmu_read_enable(mmu_read_enable), .mmu_write_enable(mmu_write_enable),
        .mmu_mem_signed_read(mmu_mem_signed_read), .mmu_mem_data_width(mmu_mem_data_width),
        .mmu_address(mmu_address), .mmu_data_in(mmu_data_in),
        .mmu_mem_ready(mmu_mem_ready), .mmu_data_out(mmu_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_mem;
        bit          we;
        bit          sgn;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mmu_out;
        int          delay;
        logic        exp_rd;
        logic        exp_wr;
        logic        exp_sgn;
        logic [1:0]  exp_w;
        logic [31:0] exp_din;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(bit is_mem, bit we, bit sgn, logic [1:0] width,
                                logic [31:0] addr, logic [31:0] wdata, logic [31:0] mmu_out,
                                int delay, logic exp_rd, logic exp_wr, logic exp_sgn,
                                logic [1:0] exp_w, logic [31:0] exp_din, logic [31:0] exp_rdata);
        vec_t v;
        v.is_mem = is_mem; v.we = we; v.sgn = sgn; v.width = width;
        v.addr = addr; v.wdata = wdata; v.mmu_out = mmu_out; v.delay = delay;
        v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_sgn = exp_sgn; v.exp_w = exp_w;
        v.exp_din = exp_din; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one table transaction. Starts and ends at a negedge with the DUT idle.
    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        mem_we = v.we; mem_signed = v.sgn; mem_width = v.width; mem_wdata = v.wdata;
        if (v.is_mem) begin
            mem_req = 1'b1; mem_addr = v.addr;
        end else begin
            if_req = 1'b1; if_addr = v.addr; mem_addr = 32'hFFFF_FFFC;
        end
        @(negedge clk);
        chk32($sformatf("v%0d addr", i), mmu_address, v.addr);
        chk1($sformatf("v%0d rd_en", i), mmu_read_enable, v.exp_rd);
        chk1($sformatf("v%0d wr_en", i), mmu_write_enable, v.exp_wr);
        chk1($sformatf("v%0d signed", i), mmu_mem_signed_read, v.exp_sgn);
        chk32($sformatf("v%0d width", i), 32'(mmu_mem_data_width), 32'(v.exp_w));
        chk32($sformatf("v%0d data_in", i), mmu_data_in, v.exp_din);
        for (int d = 0; d < v.delay; d++) begin
            @(negedge clk);
            chk32($sformatf("v%0d addr hold", i), mmu_address, v.addr);
        end
        mmu_mem_ready = 1'b1; mmu_data_out = v.mmu_out;
        @(negedge clk);
        mmu_mem_ready = 1'b0; mmu_data_out = 32'd0;
        chk1($sformatf("v%0d if_ready", i), if_ready, !v.is_mem);
        chk1($sformatf("v%0d mem_ready", i), mem_ready, v.is_mem);
        chk1($sformatf("v%0d mem_error", i), mem_error, 1'b0);
        chk32($sformatf("v%0d rdata", i), v.is_mem ? mem_rdata : if_rdata, v.exp_rdata);
        chk1($sformatf("v%0d resp strobes", i), mmu_read_enable | mmu_write_enable, 1'b0);
        mem_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk1($sformatf("v%0d ready pulse", i), if_ready | mem_ready, 1'b0);
    endtask

    // Plain word load. Starts and ends at a negedge; leaves the DUT in IDLE when no fetch is grantable.
    task automatic mem_only(input logic [31:0] addr, input logic [31:0] data);
        mem_req = 1'b1; mem_we = 1'b0; mem_signed = 1'b0; mem_width = 2'b10; mem_addr = addr;
        @(negedge clk);
        chk32("mem_only addr", mmu_address, addr);
        mmu_mem_ready = 1'b1; mmu_data_out = data;
        @(negedge clk);
        mmu_mem_ready = 1'b0;
        chk1("mem_only ready", mem_ready, 1'b1);
        chk32("mem_only rdata", mem_rdata, data);
        mem_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        if_req = 0; if_flush = 0; mem_req = 0; mem_we = 0; mem_signed = 0; mmu_mem_ready = 0;
        mem_width = 0; if_addr = 0; mem_addr = 0; mem_wdata = 0; mmu_data_out = 0;

        vecs[0] = mk(0, 1, 1, 2'b00, 32'h10,  32'h5555AAAA, 32'h00500093, 1, 1, 0, 0, 2'b10, 32'h0,        32'h00500093);
        vecs[1] = mk(1, 0, 0, 2'b10, 32'h100, 32'h0BADF00D, 32'h12345678, 0, 1, 0, 0, 2'b10, 32'h0,        32'h12345678);
        vecs[2] = mk(1, 1, 0, 2'b00, 32'h200, 32'hDEADBEEF, 32'hFFFFFFFF, 2, 0, 1, 0, 2'b00, 32'hDEADBEEF, 32'h0);
        vecs[3] = mk(1, 0, 1, 2'b01, 32'h302, 32'h00000001, 32'hFFFF8000, 3, 1, 0, 1, 2'b01, 32'h0,        32'hFFFF8000);
        vecs[4] = mk(0, 0, 0, 2'b01, 32'h44,  32'h0,        32'hCAFEF00D, 0, 1, 0, 0, 2'b10, 32'h0,        32'hCAFEF00D);
        vecs[5] = mk(1, 1, 1, 2'b01, 32'h3FC, 32'h0000BEEF, 32'h77777777, 1, 0, 1, 1, 2'b01, 32'h0000BEEF, 32'h0);

        // reset values
        #12;
        chk1("rst if_ready", if_ready, 1'b0);
        chk1("rst mem_ready", mem_ready, 1'b0);
        chk1("rst rd_en", mmu_read_enable, 1'b0);
        chk1("rst wr_en", mmu_write_enable, 1'b0);
        chk32("rst address", mmu_address, 32'd0);
        chk32("rst rdata", if_rdata | mem_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(i);

        // collision: MEM first, IF straight out of RESP
        mem_req = 1'b1; mem_we = 1'b0; mem_signed = 1'b0; mem_width = 2'b10; mem_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h14;
        @(negedge clk);
        chk32("coll mem addr", mmu_address, 32'h100);
        chk1("coll if_stall", if_stall, 1'b1);
        mmu_mem_ready = 1'b1; mmu_data_out = 32'h12345678;
        @(negedge clk);
        mmu_mem_ready = 1'b0;
        chk1("coll mem_ready", mem_ready, 1'b1);
        chk32("coll mem_rdata", mem_rdata, 32'h12345678);
        chk1("coll if_ready early", if_ready, 1'b0);
        mem_req = 1'b0;
        @(negedge clk);
        chk32("coll if addr no bubble", mmu_address, 32'h14);
        chk1("coll if rd_en", mmu_read_enable, 1'b1);
        mmu_mem_ready = 1'b1; mmu_data_out = 32'hAAAA5555;
        @(negedge clk);
        mmu_mem_ready = 1'b0;
        chk1("coll if_ready", if_ready, 1'b1);
        chk32("coll if_rdata", if_rdata, 32'hAAAA5555);
        if_req = 1'b0;
        @(negedge clk);
        chk1("coll idle", mmu_read_enable, 1'b0);

        // streak below the limit: MEM still wins over a fetch at streak 3
        if_req = 1'b1; if_addr = 32'h80; if_flush = 1'b1;
        for (int k = 0; k < 3; k++) mem_only(32'h400 + 32'(4 * k), 32'h1000 + 32'(k));
        if_flush = 1'b0;
        mem_req = 1'b1; mem_addr = 32'h40C;
        @(negedge clk);
        chk32("streak3 mem wins", mmu_address, 32'h40C);
        mmu_mem_ready = 1'b1; mmu_data_out = 32'h3;
        @(negedge clk);
        mmu_mem_ready = 1'b0;
        chk1("streak3 mem_ready", mem_ready, 1'b1);
        mem_req = 1'b0;
        @(negedge clk);
        chk32("streak3 if after resp", mmu_address, 32'h80);
        mmu_mem_ready = 1'b1; mmu_data_out = 32'h8080;
        @(negedge clk);
        mmu_mem_ready = 1'b0;
        chk1("streak3 if_ready", if_ready, 1'b1);
        if_req = 1'b0;
        @(negedge clk);

        // streak at the limit: after 4 MEM grants the pending fetch is forced ahead
        if_req = 1'b1; if_addr = 32'h84; if_flush = 1'b1;
        for (int k = 0; k < 4; k++) mem_only(32'h500 + 32'(4 * k), 32'h2000 + 32'(k));
        if_flush = 1'b0;
        mem_req = 1'b1; mem_addr = 32'h510;
        @(negedge clk);
        chk32("starve if forced", mmu_address, 32'h84);
        chk1("starve if rd_en", mmu_read_enable, 1'b1);
        mmu_mem_ready = 1'b1; mmu_data_out = 32'h0EADBEEF;
        @(negedge clk);
        mmu_mem_ready = 1'b0;
        chk1("starve if_ready", if_ready, 1'b1);
        chk32("starve if_rdata", if_rdata, 32'h0EADBEEF);
        if_req = 1'b0;
        @(negedge clk);
        chk32("starve mem resumes", mmu_address, 32'h510);
        mmu_mem_ready = 1'b1; mmu_data_out = 32'h5105;
        @(negedge clk);
        mmu_mem_ready = 1'b0;
        chk1("starve mem_ready", mem_ready, 1'b1);
        chk32("starve mem_rdata", mem_rdata, 32'h5105);
        mem_req = 1'b0;
        @(negedge clk);

        // flush during BUSY_IF: response dropped, redirected fetch served
        if_req = 1'b1; if_addr = 32'h20;
        @(negedge clk);
        chk32("flush addr 0x20", mmu_address, 32'h20);
        if_flush = 1'b1;
        @(negedge clk);
        chk1("flush access continues", mmu_read_enable, 1'b1);
        if_flush = 1'b0; if_addr = 32'h40;
        mmu_mem_ready = 1'b1; mmu_data_out = 32'h11111111;
        @(negedge clk);
        mmu_mem_ready = 1'b0;
        chk1("flush dropped ready", if_ready, 1'b0);
        chk1("flush if_stall", if_stall, 1'b1);
        @(negedge clk);
        chk1("flush idle gap", mmu_read_enable, 1'b0);
        @(negedge clk);
        chk32("flush addr 0x40", mmu_address, 32'h40);
        mmu_mem_ready = 1'b1; mmu_data_out = 32'h22222222;
        @(negedge clk);
        mmu_mem_ready = 1'b0;
        chk1("flush new if_ready", if_ready, 1'b1);
        chk32("flush new if_rdata", if_rdata, 32'h22222222);
        if_req = 1'b0;
        @(negedge clk);

        // reset mid-BUSY: strobes drop asynchronously, no response afterwards
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h600;
        @(negedge clk);
        chk1("rstmid busy rd_en", mmu_read_enable, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk1("rstmid rd_en async", mmu_read_enable, 1'b0);
        chk32("rstmid address async", mmu_address, 32'd0);
        mem_req = 1'b0;
        @(negedge clk);
        mmu_mem_ready = 1'b1; mmu_data_out = 32'h99;
        @(negedge clk);
        chk1("rstmid no ready in reset", mem_ready, 1'b0);
        mmu_mem_ready = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        chk1("rstmid no ready after", mem_ready | if_ready, 1'b0);
        chk1("rstmid idle", mmu_read_enable, 1'b0);

`ifdef ARB_TIMEOUT_EN
        begin
            int cnt;
            cnt = 0;
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h700;
            for (int i = 0; i < 400 && !mem_ready; i++) begin
                @(negedge clk);
                if (mmu_read_enable) cnt++;
            end
            chk1("tmo mem_ready", mem_ready, 1'b1);
            chk32("tmo busy cycles", 32'(cnt), 32'd255);
            chk1("tmo mem_error", mem_error, 1'b1);
            chk32("tmo rdata", mem_rdata, 32'd0);
            mem_req = 1'b0;
            @(negedge clk);
            mem_req = 1'b1; mem_addr = 32'h704;
            @(negedge clk);
            mmu_mem_ready = 1'b1; mmu_data_out = 32'h13572468;
            @(negedge clk);
            mmu_mem_ready = 1'b0;
            chk1("tmo next ready", mem_ready, 1'b1);
            chk1("tmo next no error", mem_error, 1'b0);
            chk32("tmo next rdata", mem_rdata, 32'h13572468);
            mem_req = 1'b0;
            @(negedge clk);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single MMU port between the pipeline's instruction-fetch requester (IF) and data-access requester (MEM stage load/store), replacing the hardwired fetch-only MMU drive. A per-transaction FSM latches the granted request, holds MMU controls stable until mmu_mem_ready, returns a registered one-cycle response, and supports fetch flush on taken branches. It sits between the cpu pipeline stages and the MMU.

Parameters:
MEM_STREAK_MAX, 4, consecutive MEM grants allowed while if_req is pending before IF is forced (1..15)
TIMEOUT_CYCLES, 255, BUSY cycles without mmu_mem_ready before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_ready or if_flush
if_addr  in  32  fetch address
if_flush  in  1  discard any outstanding fetch (branch taken)
if_ready  out  1  one-cycle fetch response pulse
if_rdata  out  32  fetched word, valid with if_ready
mem_req  in  1  data request; held with fields until mem_ready
mem_we  in  1  1=store, 0=load
mem_signed  in  1  signed load
mem_width  in  2  MMU width code
mem_addr  in  32  data address
mem_wdata  in  32  store data
mem_ready  out  1  one-cycle data response pulse
mem_rdata  out  32  load data, valid with mem_ready (0 for stores)
mem_error  out  1  timeout abort flag, valid with mem_ready
if_stall  out  1  if_req & ~if_ready
mem_stall  out  1  mem_req & ~mem_ready
mmu_read_enable, mmu_write_enable  out  1 each  MMU strobes
mmu_mem_signed_read  out  1  to MMU
mmu_mem_data_width  out  2  to MMU
mmu_address, mmu_data_in  out  32 each  to MMU
mmu_mem_ready  in  1  MMU completion
mmu_data_out  in  32  MMU read data

Behaviour:
- States: IDLE, BUSY_IF, BUSY_MEM, RESP. Reset: IDLE; all outputs 0; streak and timeout counters 0; drop flag 0.
- Grant (from IDLE, or from RESP excluding the requester just answered): mem_req wins unless streak == MEM_STREAK_MAX and if_req=1 (and not if_flush), then IF wins. A MEM grant increments streak only if if_req is pending; an IF grant, or mem grant with if_req=0, clears streak.
- On grant edge: latch addr/we/signed/width/wdata. IF grant latches we=0, signed=0, width=`MMU_WIDTH_WORD, wdata=0.
- BUSY_*: MMU outputs driven only from latched registers; read_enable=~we, write_enable=we; mmu_data_in = wdata for stores, else 0. Outside BUSY: strobes 0, address/data/width/signed 0.
- BUSY_* with mmu_mem_ready=1: next edge -> RESP; register mmu_data_out into the owning rdata (mem_rdata=0 for stores).
- RESP: exactly one cycle; owning ready=1 (if_ready suppressed when drop=1); then re-arbitrate (back-to-back BUSY, no IDLE bubble) or go to IDLE.
- Latency: req in IDLE at cycle 0 -> BUSY cycle 1 -> mmu_mem_ready in cycle 1 -> ready in cycle 2.
- if_flush: in BUSY_IF sets drop (the MMU access still completes, its response is discarded, and drop clears in RESP). In IDLE/RESP, a flushed if_req is not granted that cycle. A flush has no effect on MEM transactions.
- Simultaneous mem_req and if_req in IDLE with streak < max: MEM first; IF granted out of RESP.
- reset_n low mid-transaction: immediate return to reset values, MMU strobes drop asynchronously, and no response is issued.

Optional Feature:
ARB_TIMEOUT_EN: defined -> a counter runs in BUSY_*. On reaching TIMEOUT_CYCLES without mmu_mem_ready, the FSM goes to RESP with rdata=0, a ready pulse, and mem_error=1 for MEM (if_ready plus rdata 0 for IF). The counter clears on every grant. Undefined -> BUSY waits indefinitely, no counter logic is present, and mem_error is tied 0.

Test Plan:
- IF only: if_addr=0x10, mmu_mem_ready 1 cycle after enable, data 0x00500093 -> mmu_address=0x10, read_enable=1, width WORD, if_ready pulse one cycle at cycle 3 with if_rdata=0x00500093.
- Collision: mem load 0x100 (data 0x12345678) and fetch 0x14 in the same cycle -> MEM served first (mem_rdata=0x12345678), IF BUSY immediately after RESP, no IDLE cycle.
- Store: mem_we=1, addr 0x200, wdata 0xDEADBEEF, byte width -> write_enable=1, read_enable=0, mmu_data_in=0xDEADBEEF, mem_ready with mem_rdata=0.
- Starvation: mem_req held for 6 transactions with if_req high -> IF granted after the 4th MEM, then MEM resumes.
- Flush: if_flush during BUSY_IF at 0x20, then new req 0x40 -> no if_ready for 0x20, next access 0x40 with correct data; reset_n pulsed mid-BUSY -> strobes 0 immediately, no ready.
- ARB_TIMEOUT_EN defined, mmu_mem_ready held 0 -> mem_ready with mem_error=1 after 255 BUSY cycles, then next request serviced normally.
